// File: rtl/mpmc11_pkg.sv
// Shared types for the mpmc11 port arbiter: FSM state encoding and port id width.
package mpmc11_pkg;

  localparam int PORT_W = 4;

  typedef logic [PORT_W-1:0] port_id_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BUSY  = 2'd2,
    ST_TURN  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mpmc11_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_start, wrapping mod NPORT.
module mpmc11_rr_pick
  import mpmc11_pkg::*;
#(
  parameter int NPORT = 8,
  parameter int PTR_W = $clog2(NPORT)
) (
  input  logic [NPORT-1:0] i_req,
  input  logic [PTR_W-1:0] i_start,
  output logic [NPORT-1:0] o_onehot,
  output port_id_t         o_id,
  output logic             o_any
);

  logic [PTR_W:0]   w_sum;
  logic [PTR_W-1:0] w_idx;

  always_comb begin
    o_onehot = '0;
    o_id     = '0;
    o_any    = 1'b0;
    w_sum    = '0;
    w_idx    = '0;
    for (int i = 0; i < NPORT; i++) begin
      // start < NPORT and i < NPORT, so one conditional subtract performs the wrap
      w_sum = {1'b0, i_start} + (PTR_W+1)'(i);
      if (w_sum >= (PTR_W+1)'(NPORT)) begin
        w_sum = w_sum - (PTR_W+1)'(NPORT);
      end
      w_idx = w_sum[PTR_W-1:0];
      if (!o_any && i_req[w_idx]) begin
        o_any           = 1'b1;
        o_onehot[w_idx] = 1'b1;
        o_id            = port_id_t'(w_idx);
      end
    end
  end

endmodule

// File: rtl/mpmc11_port_arbiter.sv
// Round-robin arbiter for the shared controller command slot, with high/normal priority,
// post-completion turnaround gap and a busy watchdog.
//
// state    | meaning
// IDLE     | no grant; pick a winner from the eligible request set
// GRANT    | grant presented, waiting for cmd_accept (or request withdrawal)
// BUSY     | command accepted, waiting for done; watchdog running
// TURN     | grant dropped, TURN idle cycles before arbitrating again
module mpmc11_port_arbiter
  import mpmc11_pkg::*;
#(
  parameter int NPORT   = 8,
  parameter int TURN    = 1,
  parameter int TIMEOUT = 255
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [NPORT-1:0] i_req,
  input  logic [NPORT-1:0] i_hi_pri,
  input  logic             i_cmd_accept,
  input  logic             i_done,
  output logic [NPORT-1:0] o_gnt,
  output logic             o_gnt_valid,
  output port_id_t         o_port,
  output logic             o_timeout_err
);

  localparam int PTR_W = $clog2(NPORT);
  localparam int WD_W  = $clog2(TIMEOUT+1);

  arb_state_t       r_state;
  logic [PTR_W-1:0] r_ptr;
  logic [WD_W-1:0]  r_wd;
  logic [2:0]       r_turn;
  logic [NPORT-1:0] r_gnt;
  logic             r_gnt_valid;
  port_id_t         r_port;
  logic             r_timeout_err;

  logic [NPORT-1:0] w_hi_set;
  logic [NPORT-1:0] w_hi_gnt;
  logic [NPORT-1:0] w_nr_gnt;
  port_id_t         w_hi_id;
  port_id_t         w_nr_id;
  logic             w_hi_any;
  logic             w_nr_any;
  logic [NPORT-1:0] w_win_gnt;
  port_id_t         w_win_id;
  logic [PTR_W-1:0] w_port_ptr;
  logic [PTR_W-1:0] w_ptr_next;
  logic             w_wd_hit;

  assign w_hi_set = i_req & i_hi_pri;

  mpmc11_rr_pick #(.NPORT(NPORT), .PTR_W(PTR_W)) u_pick_hi (
    .i_req    (w_hi_set),
    .i_start  (r_ptr),
    .o_onehot (w_hi_gnt),
    .o_id     (w_hi_id),
    .o_any    (w_hi_any)
  );

  mpmc11_rr_pick #(.NPORT(NPORT), .PTR_W(PTR_W)) u_pick_nr (
    .i_req    (i_req),
    .i_start  (r_ptr),
    .o_onehot (w_nr_gnt),
    .o_id     (w_nr_id),
    .o_any    (w_nr_any)
  );

  assign w_win_gnt  = w_hi_any ? w_hi_gnt : w_nr_gnt;
  assign w_win_id   = w_hi_any ? w_hi_id  : w_nr_id;
  assign w_port_ptr = r_port[PTR_W-1:0];
  assign w_ptr_next = (w_port_ptr == PTR_W'(NPORT-1)) ? '0 : w_port_ptr + PTR_W'(1);
  // abort on the BUSY cycle whose increment would bring the count to TIMEOUT
  assign w_wd_hit   = (r_wd >= WD_W'(TIMEOUT-1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_ptr         <= '0;
      r_wd          <= '0;
      r_turn        <= '0;
      r_gnt         <= '0;
      r_gnt_valid   <= 1'b0;
      r_port        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_nr_any) begin
            r_gnt       <= w_win_gnt;
            r_port      <= w_win_id;
            r_gnt_valid <= 1'b1;
            r_state     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (i_cmd_accept) begin
            r_ptr   <= w_ptr_next;
            r_wd    <= '0;
            r_state <= ST_BUSY;
          end else if (!i_req[w_port_ptr]) begin
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_port      <= '0;
            r_state     <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (i_done) begin
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_port      <= '0;
            if (TURN > 0) begin
              r_turn  <= 3'(TURN-1);
              r_state <= ST_TURN;
            end else begin
              r_state <= ST_IDLE;
            end
          end else if (w_wd_hit) begin
            r_gnt         <= '0;
            r_gnt_valid   <= 1'b0;
            r_port        <= '0;
            r_timeout_err <= 1'b1;
            r_state       <= ST_IDLE;
          end else begin
            r_wd <= r_wd + WD_W'(1);
          end
        end
        ST_TURN: begin
          if (r_turn == 3'd0) begin
            r_state <= ST_IDLE;
          end else begin
            r_turn <= r_turn - 3'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_gnt         = r_gnt;
  assign o_gnt_valid   = r_gnt_valid;
  assign o_port        = r_port;
  assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mpmc11_port_arbiter.sv
// Directed bench for mpmc11_port_arbiter (NPORT=8, TURN=1, TIMEOUT=16).
module tb_mpmc11_port_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] hi;
  logic       acc;
  logic       done;
  logic [7:0] gnt;
  logic       gv;
  logic [3:0] port;
  logic       err;

  int checks   = 0;
  int failures = 0;

  wire [13:0] obs = {gnt, gv, port, err};

  always #5 clk = ~clk;

  mpmc11_port_arbiter #(.NPORT(8), .TURN(1), .TIMEOUT(16)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req         (req),
    .i_hi_pri      (hi),
    .i_cmd_accept  (acc),
    .i_done        (done),
    .o_gnt         (gnt),
    .o_gnt_valid   (gv),
    .o_port        (port),
    .o_timeout_err (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; hi = '0; acc = 1'b0; done = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // accept the current grant, complete it next cycle, then sit out the turnaround
  task automatic finish_txn();
    acc = 1'b1; tick();
    acc = 1'b0; done = 1'b1; tick();
    done = 1'b0; tick();
  endtask

  task automatic test_reset();
    logic [13:0] exp;
    rst = 1'b1; req = 8'hFF; hi = 8'hFF; acc = 1'b1; done = 1'b1;
    tick(); tick();
    exp = '0;
    checks++; if (obs !== exp) begin failures++; $display("FAIL reset_outputs got=%h exp=%h", obs, exp); end
    rst = 1'b0; req = '0; hi = '0; acc = 1'b0; done = 1'b0;
    tick();
    checks++; if (obs !== exp) begin failures++; $display("FAIL reset_idle got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_basic();
    logic [13:0] exp;
    do_reset();
    req = 8'h04; tick();
    exp = {8'h04, 1'b1, 4'd2, 1'b0};
    checks++; if (obs !== exp) begin failures++; $display("FAIL basic_grant got=%h exp=%h", obs, exp); end
    acc = 1'b1; tick();
    acc = 1'b0; req = '0;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (obs !== exp) begin failures++; $display("FAIL basic_busy_hold got=%h exp=%h", obs, exp); end
    done = 1'b1; tick();
    done = 1'b0; req = 8'hFF;
    exp = '0;
    checks++; if (obs !== exp) begin failures++; $display("FAIL basic_turnaround got=%h exp=%h", obs, exp); end
    tick();
    checks++; if (obs !== exp) begin failures++; $display("FAIL basic_idle_gap got=%h exp=%h", obs, exp); end
    tick();
    exp = {8'h08, 1'b1, 4'd3, 1'b0};
    checks++; if (obs !== exp) begin failures++; $display("FAIL basic_ptr_next got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_rotation();
    logic [13:0] exp;
    do_reset();
    req = 8'hFF; tick();
    for (int k = 0; k < 9; k++) begin
      exp = {8'(1 << (k % 8)), 1'b1, 4'(k % 8), 1'b0};
      checks++; if (obs !== exp) begin failures++; $display("FAIL rotation_%0d got=%h exp=%h", k, obs, exp); end
      finish_txn();
      tick();
    end
  endtask

  task automatic test_priority();
    logic [13:0] exp;
    do_reset();
    req = 8'hFF; hi = 8'h20;
    for (int k = 0; k < 3; k++) begin
      tick();
      exp = {8'h20, 1'b1, 4'd5, 1'b0};
      checks++; if (obs !== exp) begin failures++; $display("FAIL priority_hi_%0d got=%h exp=%h", k, obs, exp); end
      finish_txn();
    end
    hi = '0; tick();
    exp = {8'h40, 1'b1, 4'd6, 1'b0};
    checks++; if (obs !== exp) begin failures++; $display("FAIL priority_drop got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_withdraw();
    logic [13:0] exp;
    do_reset();
    acc = 1'b1; done = 1'b1; tick();
    acc = 1'b0; done = 1'b0;
    exp = '0;
    checks++; if (obs !== exp) begin failures++; $display("FAIL stray_strobes got=%h exp=%h", obs, exp); end
    req = 8'h08; tick();
    exp = {8'h08, 1'b1, 4'd3, 1'b0};
    checks++; if (obs !== exp) begin failures++; $display("FAIL withdraw_grant got=%h exp=%h", obs, exp); end
    req = '0; tick();
    exp = '0;
    checks++; if (obs !== exp) begin failures++; $display("FAIL withdraw_clear got=%h exp=%h", obs, exp); end
    req = 8'hFF; tick();
    exp = {8'h01, 1'b1, 4'd0, 1'b0};
    checks++; if (obs !== exp) begin failures++; $display("FAIL withdraw_ptr_kept got=%h exp=%h", obs, exp); end
    req = '0; acc = 1'b1; tick();
    acc = 1'b0; tick();
    checks++; if (obs !== exp) begin failures++; $display("FAIL accept_beats_withdraw got=%h exp=%h", obs, exp); end
    done = 1'b1; tick();
    done = 1'b0; req = 8'hFF; tick(); tick();
    exp = {8'h02, 1'b1, 4'd1, 1'b0};
    checks++; if (obs !== exp) begin failures++; $display("FAIL withdraw_ptr_adv got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_watchdog();
    logic [13:0] exp;
    do_reset();
    req = 8'h04; tick();
    acc = 1'b1; tick();
    acc = 1'b0; req = '0;
    for (int t = 1; t <= 15; t++) tick();
    exp = {8'h04, 1'b1, 4'd2, 1'b0};
    checks++; if (obs !== exp) begin failures++; $display("FAIL wd_before_abort got=%h exp=%h", obs, exp); end
    tick();
    exp = {8'h00, 1'b0, 4'd0, 1'b1};
    checks++; if (obs !== exp) begin failures++; $display("FAIL wd_abort got=%h exp=%h", obs, exp); end
    req = 8'hFF; tick();
    exp = {8'h08, 1'b1, 4'd3, 1'b0};
    checks++; if (obs !== exp) begin failures++; $display("FAIL wd_pulse_regrant got=%h exp=%h", obs, exp); end

    do_reset();
    req = 8'h04; tick();
    acc = 1'b1; tick();
    acc = 1'b0; req = '0;
    for (int t = 1; t <= 15; t++) tick();
    done = 1'b1; tick();
    done = 1'b0;
    exp = '0;
    checks++; if (obs !== exp) begin failures++; $display("FAIL wd_boundary_done got=%h exp=%h", obs, exp); end
    tick();
    checks++; if (obs !== exp) begin failures++; $display("FAIL wd_boundary_after got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_reset_mid_busy();
    logic [13:0] exp;
    do_reset();
    req = 8'h20; tick();
    acc = 1'b1; tick();
    acc = 1'b0; tick();
    rst = 1'b1; req = '0; tick();
    rst = 1'b0;
    exp = '0;
    checks++; if (obs !== exp) begin failures++; $display("FAIL midbusy_reset got=%h exp=%h", obs, exp); end
    req = 8'h80; tick();
    exp = {8'h80, 1'b1, 4'd7, 1'b0};
    checks++; if (obs !== exp) begin failures++; $display("FAIL midbusy_regrant got=%h exp=%h", obs, exp); end
    req = '0; tick();
    req = 8'hFF; tick();
    exp = {8'h01, 1'b1, 4'd0, 1'b0};
    checks++; if (obs !== exp) begin failures++; $display("FAIL midbusy_ptr_zero got=%h exp=%h", obs, exp); end
  endtask

  initial begin
    rst = 1'b1; req = '0; hi = '0; acc = 1'b0; done = 1'b0;
    test_reset();
    test_basic();
    test_rotation();
    test_priority();
    test_withdraw();
    test_watchdog();
    test_reset_mid_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
